request_decoder: RTL and testbench

- Read side of the request FIFO between AXI address capture and the DRAM cache controller.
- Pops 128-bit request entries, decodes them into rw/id/address, and splits the address into index and tag.
- Presents each request to the cache lookup stage over a valid/ready handshake.
- Tracks in-flight requests and stops popping at a configurable outstanding limit.

---
 rtl/dram_cache_pkg.sv | 30 +++
 rtl/request_decoder_outstanding_counter.sv | 39 +++
 rtl/request_decoder.sv | 127 ++++++++++++
 tb/tb_request_decoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_cache_pkg.sv
// Shared definitions for the DRAM cache request path.
// The FIFO entry writer and the request decoder both use these field offsets.
package dram_cache_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_ID_WIDTH   = 32;

    // Entry layout: rw in bit 0, then the id, then the address. Upper bits are spare.
    localparam int RW_BIT   = 0;
    localparam int ID_LSB   = 1;
    localparam int ADDR_LSB = ID_LSB + DEF_ID_WIDTH;

    typedef struct packed {
        logic                      write;
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_ADDR_WIDTH-1:0] addr;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2,
        ISSUE = 2'd3
    } state_t;

    function automatic int addr_lsb(input int id_width);
        return ID_LSB + id_width;
    endfunction

endpackage

// File: rtl/request_decoder_outstanding_counter.sv
// Saturating up/down count of issued-but-not-completed requests.
// A decrement at zero leaves the count alone and sets a sticky underflow flag.
module outstanding_counter #(
    parameter int MAX_COUNT   = 8,
    parameter int COUNT_WIDTH = $clog2(MAX_COUNT + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_inc,
    input  logic                   i_dec,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_underflow
);

    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_underflow;

    // Simultaneous increment and decrement cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else if (i_inc && !i_dec) begin
            if (r_count != COUNT_WIDTH'(MAX_COUNT)) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
        end else if (i_dec && !i_inc) begin
            if (r_count == '0) begin
                r_underflow <= 1'b1;
            end else begin
                r_count <= r_count - COUNT_WIDTH'(1);
            end
        end
    end

    assign o_count     = r_count;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/request_decoder.sv
// Pops request entries from the AXI address FIFO, decodes them and hands them
// to the cache lookup stage, throttled by the number of in-flight requests.
module request_decoder
    import dram_cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 32,
    parameter int INDEX_BIT_SIZE  = 4,
    parameter int FIFO_WIDTH      = 128,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 fifo_empty,
    output logic                                 fifo_read_enable,
    input  logic [FIFO_WIDTH-1:0]                fifo_o,
    output logic                                 req_valid_o,
    input  logic                                 req_ready_i,
    output logic                                 req_write_o,
    output logic [ID_WIDTH-1:0]                  req_id_o,
    output logic [ADDR_WIDTH-1:0]                req_addr_o,
    output logic [INDEX_BIT_SIZE-1:0]            req_index_o,
    output logic [ADDR_WIDTH-INDEX_BIT_SIZE-1:0] req_tag_o,
    input  logic                                 done_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 busy_o,
    output logic                                 err_o
);

    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int A_LSB    = addr_lsb(ID_WIDTH);
    localparam int USED_TOP = A_LSB + ADDR_WIDTH;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_write;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_W-1:0]      w_outstanding;
    logic                  w_accept;
    logic                  w_room_now;
    logic                  w_room_after_accept;

    assign w_accept            = req_valid_o && req_ready_i;
    assign w_room_now          = int'(w_outstanding) < MAX_OUTSTANDING;
    assign w_room_after_accept = (int'(w_outstanding) + 1) < MAX_OUTSTANDING;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The back-to-back check in ISSUE counts the request being accepted this cycle.
    always_comb begin
        w_next_state     = r_state;
        fifo_read_enable = 1'b0;
        req_valid_o      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!fifo_empty && w_room_now) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                fifo_read_enable = 1'b1;
                w_next_state     = LATCH;
            end
            LATCH: begin
                w_next_state = ISSUE;
            end
            ISSUE: begin
                req_valid_o = 1'b1;
                if (req_ready_i) begin
                    if (!fifo_empty && w_room_after_accept) begin
                        w_next_state = FETCH;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_id    <= '0;
            r_addr  <= '0;
        end else if (r_state == LATCH) begin
            r_write <= fifo_o[RW_BIT];
            r_id    <= fifo_o[ID_LSB +: ID_WIDTH];
            r_addr  <= fifo_o[A_LSB +: ADDR_WIDTH];
        end
    end

    generate
        if (FIFO_WIDTH > USED_TOP) begin : g_spare_bits
            logic w_unused_upper;
            assign w_unused_upper = ^fifo_o[FIFO_WIDTH-1:USED_TOP];
        end
    endgenerate

    outstanding_counter #(
        .MAX_COUNT   (MAX_OUTSTANDING),
        .COUNT_WIDTH (CNT_W)
    ) u_outstanding (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_inc       (w_accept),
        .i_dec       (done_i),
        .o_count     (w_outstanding),
        .o_underflow (err_o)
    );

    assign req_write_o   = r_write;
    assign req_id_o      = r_id;
    assign req_addr_o    = r_addr;
    assign req_index_o   = r_addr[INDEX_BIT_SIZE-1:0];
    assign req_tag_o     = r_addr[ADDR_WIDTH-1:INDEX_BIT_SIZE];
    assign outstanding_o = w_outstanding;
    assign busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_request_decoder.sv
// Directed and randomized checks of request_decoder against a FIFO model and
// a scoreboard of decoded requests and in-flight counts.
module tb_request_decoder;

    localparam int AW  = 32;
    localparam int IW  = 32;
    localparam int IB  = 4;
    localparam int FW  = 128;
    localparam int MAX = 2;
    localparam int CW  = $clog2(MAX + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fifo_empty;
    logic              fifo_read_enable;
    logic [FW-1:0]     fifo_o;
    logic              req_valid_o;
    logic              req_ready_i;
    logic              req_write_o;
    logic [IW-1:0]     req_id_o;
    logic [AW-1:0]     req_addr_o;
    logic [IB-1:0]     req_index_o;
    logic [AW-IB-1:0]  req_tag_o;
    logic              done_i;
    logic [CW-1:0]     outstanding_o;
    logic              busy_o;
    logic              err_o;

    logic [FW-1:0] mem [0:1023];
    int pushCount = 0;
    int popCount  = 0;

    int nCompared = 0;
    int nMismatch = 0;

    int   acceptIdx = 0;
    int   mOut = 0;
    logic mErr = 1'b0;
    logic holdPending = 1'b0;
    logic [64:0] holdPayload = '0;

    request_decoder #(
        .ADDR_WIDTH      (AW),
        .ID_WIDTH        (IW),
        .INDEX_BIT_SIZE  (IB),
        .FIFO_WIDTH      (FW),
        .MAX_OUTSTANDING (MAX)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .fifo_o           (fifo_o),
        .req_valid_o      (req_valid_o),
        .req_ready_i      (req_ready_i),
        .req_write_o      (req_write_o),
        .req_id_o         (req_id_o),
        .req_addr_o       (req_addr_o),
        .req_index_o      (req_index_o),
        .req_tag_o        (req_tag_o),
        .done_i           (done_i),
        .outstanding_o    (outstanding_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: data appears on fifo_o the cycle after a pop.
    assign fifo_empty = (popCount >= pushCount);

    always @(posedge clk) begin
        if (fifo_read_enable) begin
            fifo_o   <= mem[popCount % 1024];
            popCount <= popCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic done);
        req_ready_i = ready;
        done_i      = done;
    endtask

    function automatic logic [127:0] makeEntry(input logic [127:0] addr, input logic [127:0] id,
                                               input logic [127:0] rw, input logic [127:0] spare);
        return (spare << 100) + (addr << 33) + (id << 1) + rw;
    endfunction

    task automatic pushEntry(input logic [127:0] e);
        mem[pushCount % 1024] = e;
        pushCount = pushCount + 1;
    endtask

    // Checks that apply to the inputs and outputs seen just before a clock edge.
    task automatic preEdge();
        logic [127:0] e;
        logic [127:0] expAddr;
        logic         acc;
        if (fifo_read_enable) checkOutput("pop_nonempty", fifo_empty, 0);
        if (holdPending) begin
            checkOutput("hold_valid", req_valid_o, 1);
            checkOutput("hold_payload", {req_write_o, req_id_o, req_addr_o}, holdPayload);
        end
        acc = req_valid_o && req_ready_i;
        if (acc) begin
            e       = mem[acceptIdx % 1024];
            expAddr = (e >> 33) % (128'd1 << AW);
            checkOutput("acc_write", req_write_o, e % 2);
            checkOutput("acc_id", req_id_o, (e >> 1) % (128'd1 << IW));
            checkOutput("acc_addr", req_addr_o, expAddr);
            checkOutput("acc_index", req_index_o, expAddr % 16);
            checkOutput("acc_tag", req_tag_o, expAddr / 16);
            acceptIdx++;
        end
        holdPending = req_valid_o && !req_ready_i;
        holdPayload = {req_write_o, req_id_o, req_addr_o};
        if (acc && !done_i) mOut++;
        else if (!acc && done_i) begin
            if (mOut == 0) mErr = 1'b1;
            else mOut--;
        end
    endtask

    task automatic postEdge();
        checkOutput("outstanding", outstanding_o, mOut);
        checkOutput("err", err_o, mErr);
    endtask

    task automatic cycle();
        if (rst_n) preEdge();
        @(posedge clk);
        @(negedge clk);
        if (rst_n) postEdge();
    endtask

    task automatic waitValid(input string tag);
        for (int i = 0; i < 12; i++) begin
            if (req_valid_o) break;
            cycle();
        end
        checkOutput(tag, req_valid_o, 1);
    endtask

    initial begin
        int startIdx;
        int popBefore;

        rst_n = 1'b0;
        applyStimulus(0, 0);
        $display("[TB] reset with a pending entry");
        pushEntry(makeEntry(128'h0000_1234, 5, 0, 0));
        repeat (3) begin
            cycle();
            checkOutput("rst_rden", fifo_read_enable, 0);
        end
        checkOutput("rst_valid", req_valid_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_out", outstanding_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_payload", {req_write_o, req_id_o, req_addr_o, req_index_o, req_tag_o}, 0);

        $display("[TB] single read");
        rst_n = 1'b1;
        applyStimulus(1, 0);
        cycle();
        checkOutput("rd_rden", fifo_read_enable, 1);
        cycle();
        checkOutput("rd_latch_valid", req_valid_o, 0);
        cycle();
        checkOutput("rd_valid", req_valid_o, 1);
        checkOutput("rd_write", req_write_o, 0);
        checkOutput("rd_id", req_id_o, 5);
        checkOutput("rd_index", req_index_o, 4'h4);
        checkOutput("rd_tag", req_tag_o, 28'h0000123);
        cycle();
        checkOutput("rd_out", outstanding_o, 1);
        checkOutput("rd_idle", busy_o, 0);

        $display("[TB] backpressure on a write");
        applyStimulus(0, 0);
        pushEntry(makeEntry(128'hDEAD_BEEF, 7, 1, 128'hA5));
        cycle();
        checkOutput("bp_rden", fifo_read_enable, 1);
        cycle();
        cycle();
        checkOutput("bp_valid", req_valid_o, 1);
        popBefore = popCount;
        repeat (5) cycle();
        checkOutput("bp_valid_held", req_valid_o, 1);
        checkOutput("bp_write", req_write_o, 1);
        checkOutput("bp_id", req_id_o, 7);
        checkOutput("bp_index", req_index_o, 4'hF);
        checkOutput("bp_tag", req_tag_o, 28'hDEADBEE);
        checkOutput("bp_single_pop", popCount, popBefore);
        applyStimulus(1, 0);
        cycle();
        checkOutput("bp_out", outstanding_o, 2);
        applyStimulus(1, 1);
        cycle();
        cycle();
        applyStimulus(1, 0);
        checkOutput("bp_drained", outstanding_o, 0);

        $display("[TB] outstanding limit");
        startIdx = acceptIdx;
        for (int i = 0; i < 4; i++) pushEntry(makeEntry(128'h100 + i, 20 + i, i % 2, 0));
        repeat (15) cycle();
        checkOutput("lim_issued", acceptIdx - startIdx, 2);
        checkOutput("lim_idle", busy_o, 0);
        checkOutput("lim_nonempty", fifo_empty, 0);
        checkOutput("lim_out", outstanding_o, 2);
        applyStimulus(1, 1);
        cycle();
        applyStimulus(1, 0);
        repeat (8) cycle();
        checkOutput("lim_third", acceptIdx - startIdx, 3);
        checkOutput("lim_out2", outstanding_o, 2);

        $display("[TB] accept and done together");
        applyStimulus(0, 1);
        cycle();
        applyStimulus(0, 0);
        waitValid("sim_wait_valid");
        checkOutput("sim_out_before", outstanding_o, 1);
        applyStimulus(1, 1);
        cycle();
        checkOutput("sim_out", outstanding_o, 1);
        applyStimulus(0, 1);
        cycle();
        applyStimulus(0, 0);
        checkOutput("sim_drained", outstanding_o, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 3 == 0) && (pushCount - popCount < 6))
                pushEntry({$urandom(), $urandom(), $urandom(), $urandom()});
            applyStimulus(1'($urandom % 2), (mOut > 0) && ($urandom % 4 == 0));
            cycle();
        end
        for (int i = 0; i < 500; i++) begin
            if (acceptIdx == pushCount && mOut == 0 && !busy_o) break;
            applyStimulus(1, mOut > 0);
            cycle();
        end
        applyStimulus(0, 0);
        checkOutput("rand_all_issued", acceptIdx, pushCount);
        checkOutput("rand_out_zero", outstanding_o, 0);

        $display("[TB] underflow");
        applyStimulus(0, 1);
        cycle();
        applyStimulus(0, 0);
        checkOutput("uf_err", err_o, 1);
        checkOutput("uf_out", outstanding_o, 0);
        repeat (3) cycle();
        checkOutput("uf_err_sticky", err_o, 1);

        $display("[TB] async reset during issue");
        pushEntry(makeEntry(128'h55, 9, 0, 0));
        waitValid("ar_wait_valid");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", req_valid_o, 0);
        checkOutput("ar_busy", busy_o, 0);
        checkOutput("ar_err", err_o, 0);
        checkOutput("ar_out", outstanding_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
